// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
//   Bundles the icache, dcache and RAM-side signals of the cache/memory arbiter.
//   Ports (as seen from the arbiter, modport slave):
//     iREN/iaddr  in   icache read request and address
//     iload/iwait out  icache read data and stall
//     dREN/dWEN   in   dcache read/write request (write wins)
//     daddr/dstore in  dcache address and write data
//     dload/dwait out  dcache read data and stall
//     ramREN/ramWEN/ramaddr/ramstore out  RAM strobes, address, write data
//     ramload/ramready in                 RAM read data, access complete
//   modport master is the environment side (caches + RAM model).
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              iwait;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dwait;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramready;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one RAM port between the icache (read-only) and the dcache
//   (read/write). The dcache has fixed priority; a grant always returns to
//   IDLE for one turnaround cycle before the next grant is decided.
//   Ports:
//     CLK  in  clock, rising edge
//     RST  in  asynchronous active-high reset
//     bus  cache_mem_arbiter_if.slave  cache and RAM signals
//   Optional feature macro: ARB_STARVE_GUARD_EN
//     When defined, a saturating counter of icache losses forces an icache
//     grant once STARVE_MAX dcache grants were made while the icache waited.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 4
`endif
) (
  input logic                 CLK,
  input logic                 RST,
  cache_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t            state;
  logic              dreq;
  logic              starve_hit;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] store_mux;

  assign dreq = bus.dREN | bus.dWEN;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  // Icache has lost STARVE_MAX decisions in a row and is still asking.
  assign starve_hit = bus.iREN && (starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.iREN) begin
            starve_cnt <= '0;
          end else if (!starve_hit && dreq && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        IGRANT: begin
          if (bus.iREN && bus.ramready) begin
            starve_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Arbitration state. Dropping the request mid-grant aborts back to IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (starve_hit) begin
            state <= IGRANT;
          end else if (dreq) begin
            state <= DGRANT;
          end else if (bus.iREN) begin
            state <= IGRANT;
          end
        end
        IGRANT: begin
          if (!bus.iREN || bus.ramready) begin
            state <= IDLE;
          end
        end
        DGRANT: begin
          if (!dreq || bus.ramready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes follow the owner's live request so an abort drops them at once.
  // A stalled requester sees wait=request; wait is never high without one.
  always_comb begin
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    addr_mux   = '0;
    store_mux  = '0;
    bus.iwait  = bus.iREN;
    bus.dwait  = dreq;
    case (state)
      DGRANT: begin
        addr_mux   = bus.daddr;
        store_mux  = bus.dstore;
        bus.ramWEN = bus.dWEN;
        bus.ramREN = bus.dREN & ~bus.dWEN;
        bus.dwait  = dreq & ~bus.ramready;
      end
      IGRANT: begin
        addr_mux   = bus.iaddr;
        bus.ramREN = bus.iREN;
        bus.iwait  = bus.iREN & ~bus.ramready;
      end
      default: ;
    endcase
  end

  assign bus.ramaddr  = addr_mux;
  assign bus.ramstore = store_mux;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;

endmodule
